conv_mac_pipe: RTL

//  Parametrised, pipelined KxK convolution MAC; successor of the fixed 3x3 combinational CONV.

---
 rtl/conv_pkg.sv | 39 +++
 rtl/conv_add_tree.sv | 61 ++++++
 rtl/conv_mac_pipe.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the pipelined convolution MAC:
//   - default pixel/weight width (taken from `Pixel_DataSize when defined)
//   - output/accumulator width function and channel-counter width function
//   - per-stage control bundle carried alongside the datapath
//   - CONV_TAP macro: slice tap <idx> of width <w> out of a flat tap vector
// ---------------------------------------------------------------------------
`ifndef Pixel_DataSize
`define Pixel_DataSize 8
`endif

`ifndef CONV_TAP
`define CONV_TAP(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package conv_pkg;

  localparam int DW_DEF = `Pixel_DataSize;

  // Signed result width: full product, growth of the KN-tap sum, growth of the
  // channel accumulation, plus one bit so no combination of operands overflows.
  function automatic int ow_calc(input int dw, input int kn, input int nch);
    return 2 * dw + $clog2(kn) + $clog2(nch) + 1;
  endfunction

  // Channel counter width; a single-channel build still needs a 1-bit counter.
  function automatic int cnt_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Control travelling with each window through the pipeline.
  typedef struct packed {
    logic v;     // stage holds a real window
    logic last;  // window is the last channel of its group
    logic relu;  // relu_en sampled when the window was accepted
  } stage_ctl_t;

endpackage

// File: rtl/conv_add_tree.sv
// ---------------------------------------------------------------------------
// conv_add_tree
// Balanced signed adder tree over KN products with a registered output.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (clears the sum register)
//   en       in   register update enable (pipeline not stalled)
//   prod_in  in   KN*PW flat signed products, tap i at [i*PW +: PW]
//   sum_out  out  OW-bit signed registered sum
// ---------------------------------------------------------------------------
module conv_add_tree
  import conv_pkg::*;
#(
  parameter int KN = 9,
  parameter int PW = 16,
  parameter int OW = 23
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [KN*PW-1:0]   prod_in,
  output logic [OW-1:0]      sum_out
);

  // Leaves padded with zeros up to the next power of two; node j sums 2j and 2j+1.
  localparam int NP = 1 << $clog2(KN);

  logic signed [OW-1:0] node [2*NP];
  logic signed [OW-1:0] sum_d;
  logic signed [OW-1:0] sum_q;

  // Sign-extend every product into a leaf and reduce pairwise to the root.
  always_comb begin
    node = '{default: '0};
    for (int i = 0; i < NP; i++) begin
      if (i < KN) begin
        node[NP + i] = OW'($signed(`CONV_TAP(prod_in, i, PW)));
      end else begin
        node[NP + i] = '0;
      end
    end
    for (int j = NP - 1; j >= 1; j--) begin
      node[j] = node[2*j] + node[2*j + 1];
    end
    sum_d = node[1];
  end

  // Sum register; frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_d;
    end else begin
      sum_q <= sum_q;
    end
  end

  assign sum_out = sum_q;

endmodule

// File: rtl/conv_mac_pipe.sv
// ---------------------------------------------------------------------------
// conv_mac_pipe
// Pipelined KN-tap convolution MAC accumulating NUM_CH channels per result.
//   S1: per-tap signed multiply against the weight bank (registered)
//   S2: adder tree (conv_add_tree, registered)
//   S3: channel accumulator and output register with optional ReLU
// The whole pipeline freezes while a result is held unaccepted.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   w_w, w_in            weight bank write strobe and KN*DW signed weights
//   if_valid, if_ready   ifmap window handshake; if_in is KN*DW signed taps
//   relu_en              ReLU select, taken with the last-channel window
//   out_valid, out_ready result handshake; out is OW-bit signed result
// ---------------------------------------------------------------------------
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int KN     = 9,
  parameter int NUM_CH = 4,
  localparam int OW    = ow_calc(DW, KN, NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_w,
  input  logic [KN*DW-1:0]  w_in,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [KN*DW-1:0]  if_in,
  input  logic              relu_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out
);

  localparam int PW = 2 * DW;
  localparam int CW = cnt_w(NUM_CH);

  logic [KN*DW-1:0]     w_q, w_d;
  logic [CW-1:0]        ch_cnt_q, ch_cnt_d;
  logic [KN*PW-1:0]     prod_q, prod_d;
  stage_ctl_t           ctl1_q, ctl1_d;
  stage_ctl_t           ctl2_q, ctl2_d;
  logic signed [OW-1:0] acc_q, acc_d;
  logic signed [OW-1:0] out_q, out_d;
  logic                 out_valid_q, out_valid_d;

  logic                 stall;
  logic                 adv;
  logic                 accept;
  logic                 last_ch;
  logic [OW-1:0]        sum_s;
  logic signed [OW-1:0] res_s;

  // Weight bank next state; writes never wait for the pipeline.
  always_comb begin
    w_d = w_q;
    if (w_w) begin
      w_d = w_in;
    end else begin
      w_d = w_q;
    end
  end

  // Handshake, channel counter and multiplier stage.
  always_comb begin
    stall    = out_valid_q & ~out_ready;
    adv      = ~stall;
    accept   = if_valid & adv;
    last_ch  = (ch_cnt_q == CW'(NUM_CH - 1));
    ch_cnt_d = ch_cnt_q;
    prod_d   = prod_q;
    ctl1_d   = ctl1_q;
    if (accept) begin
      if (last_ch) begin
        ch_cnt_d = '0;
      end else begin
        ch_cnt_d = ch_cnt_q + CW'(1);
      end
    end else begin
      ch_cnt_d = ch_cnt_q;
    end
    if (adv) begin
      // w_q is the pre-write bank, so a same-cycle w_w only affects later windows.
      for (int i = 0; i < KN; i++) begin
        `CONV_TAP(prod_d, i, PW) = PW'($signed(`CONV_TAP(if_in, i, DW)))
                                 * PW'($signed(`CONV_TAP(w_q, i, DW)));
      end
      ctl1_d.v    = if_valid;
      ctl1_d.last = last_ch;
      ctl1_d.relu = relu_en;
    end else begin
      prod_d = prod_q;
      ctl1_d = ctl1_q;
    end
  end

  // Control follows the adder tree register.
  always_comb begin
    ctl2_d = ctl2_q;
    if (adv) begin
      ctl2_d = ctl1_q;
    end else begin
      ctl2_d = ctl2_q;
    end
  end

  // Accumulator and output register; acc is zero at every group start, so the
  // first channel needs no special case.
  always_comb begin
    res_s       = acc_q + $signed(sum_s);
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      if (ctl2_q.v) begin
        if (ctl2_q.last) begin
          acc_d       = '0;
          out_d       = (ctl2_q.relu && res_s[OW-1]) ? '0 : res_s;
          out_valid_d = 1'b1;
        end else begin
          acc_d       = res_s;
          out_valid_d = 1'b0;
        end
      end else begin
        // Either nothing was pending or the consumer just took it.
        out_valid_d = 1'b0;
      end
    end else begin
      acc_d       = acc_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= '0;
      ch_cnt_q    <= '0;
      prod_q      <= '0;
      ctl1_q      <= '0;
      ctl2_q      <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      w_q         <= w_d;
      ch_cnt_q    <= ch_cnt_d;
      prod_q      <= prod_d;
      ctl1_q      <= ctl1_d;
      ctl2_q      <= ctl2_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  conv_add_tree #(
    .KN (KN),
    .PW (PW),
    .OW (OW)
  ) u_add_tree (
    .clk     (clk),
    .rst     (rst),
    .en      (adv),
    .prod_in (prod_q),
    .sum_out (sum_s)
  );

  assign if_ready  = adv;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule
